// File: rtl/gray_step_decoder.sv
// Receive-side decoder for a 3-bit Gray up/down counter: recovers binary value,
// step direction, a wrapping position count and a saturating illegal-jump count.
module gray_step_decoder #(
   parameter int unsigned POS_W = 8,
   parameter int unsigned ERR_W = 4
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             EN,
   input  logic [2:0]       G,
   output logic [2:0]       BIN,
   output logic             VALID,
   output logic             STEP,
   output logic             DIR,
   output logic             ERR,
   output logic [POS_W-1:0] POS,
   output logic [ERR_W-1:0] ERR_CNT
);

   typedef enum logic [0:0] {StInit, StTrack} state_t;

   state_t     state;
   logic [2:0] p;
   logic [2:0] b;
   logic [2:0] d;

   always_comb begin
      b[2] = G[2];
      b[1] = G[2] ^ G[1];
      b[0] = G[2] ^ G[1] ^ G[0];
      d    = b - p;
   end

   // BIN always mirrors the previous-value register.
   assign BIN   = p;
   assign VALID = (state == StTrack);

   always_ff @(posedge CLK) begin
      if (reset) begin
         state   <= StInit;
         p       <= 3'b000;
         STEP    <= 1'b0;
         DIR     <= 1'b0;
         ERR     <= 1'b0;
         POS     <= '0;
         ERR_CNT <= '0;
      end else begin
         STEP <= 1'b0;
         ERR  <= 1'b0;
         if (EN) begin
            p <= b;
            case (state)
               StInit: begin
                  state <= StTrack;
               end
               StTrack: begin
                  if (d == 3'd1) begin
                     STEP <= 1'b1;
                     DIR  <= 1'b1;
                     POS  <= POS + POS_W'(1);
                  end else if (d == 3'd7) begin
                     STEP <= 1'b1;
                     DIR  <= 1'b0;
                     POS  <= POS - POS_W'(1);
                  end else if (d != 3'd0) begin
                     ERR <= 1'b1;
                     if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + ERR_W'(1);
                  end
               end
               default: state <= StInit;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gray_step_decoder.sv
// Scoreboard bench for gray_step_decoder: a behavioural model predicts each edge's
// outputs, which are queued at drive time and compared one cycle later.
module tb_gray_step_decoder;

   localparam int POS_W = 8;
   localparam int ERR_W = 4;

   logic             CLK = 1'b0;
   logic             reset = 1'b1;
   logic             EN = 1'b0;
   logic [2:0]       G = 3'b000;
   logic [2:0]       BIN;
   logic             VALID, STEP, DIR, ERR;
   logic [POS_W-1:0] POS;
   logic [ERR_W-1:0] ERR_CNT;

   gray_step_decoder #(.POS_W(POS_W), .ERR_W(ERR_W)) dut (
      .CLK(CLK), .reset(reset), .EN(EN), .G(G), .BIN(BIN), .VALID(VALID),
      .STEP(STEP), .DIR(DIR), .ERR(ERR), .POS(POS), .ERR_CNT(ERR_CNT)
   );

   always #5 CLK = ~CLK;

   typedef logic [3+4+POS_W+ERR_W-1:0] obs_t;
   obs_t obs;
   assign obs = {BIN, VALID, STEP, DIR, ERR, POS, ERR_CNT};

   obs_t sb[$];
   obs_t e;
   int   checks = 0;
   int   errors = 0;

   // Model state
   bit       m_valid = 0;
   bit [2:0] m_p = 0;
   bit       m_dir = 0;
   int       m_pos = 0;
   int       m_errc = 0;

   task automatic step(input logic r, input logic en, input logic [2:0] g);
      bit [2:0] bb;
      int       dd;
      bit       st, er;
      reset = r;
      EN    = en;
      G     = g;
      bb[2] = g[2];
      for (int i = 1; i >= 0; i--) bb[i] = bb[i+1] ^ g[i];
      st = 0;
      er = 0;
      if (r) begin
         m_valid = 0; m_p = 0; m_dir = 0; m_pos = 0; m_errc = 0;
      end else if (en) begin
         if (!m_valid) begin
            m_valid = 1;
         end else begin
            dd = (int'(bb) - int'(m_p) + 8) % 8;
            if (dd == 1) begin
               st = 1; m_dir = 1; m_pos = (m_pos + 1) % 256;
            end else if (dd == 7) begin
               st = 1; m_dir = 0; m_pos = (m_pos + 255) % 256;
            end else if (dd != 0) begin
               er = 1;
               if (m_errc < 15) m_errc++;
            end
         end
         m_p = bb;
      end
      sb.push_back({m_p, m_valid, st, m_dir, er, POS_W'(m_pos), ERR_W'(m_errc)});
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 3'b011);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset_edge%0d got %h want %h", i, obs, e);
         end
         checks++;
         if (VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", VALID);
         end
      end
      step(1'b0, 1'b1, 3'b000);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL baseline got %h want %h", obs, e);
      end
      checks++;
      if ({VALID, BIN, STEP, POS} !== {1'b1, 3'b000, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL baseline_fields got v%b b%0d s%b p%0d want v1 b0 s0 p0",
                  VALID, BIN, STEP, POS);
      end
   endtask

   task automatic test_count_up;
      logic [2:0] seq [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
      int steps = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, seq[i]);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL up_%0d got %h want %h", i, obs, e);
         end
         checks++;
         if (BIN !== 3'((i + 1) % 8) || DIR !== 1'b1) begin
            errors++;
            $display("FAIL up_bin_%0d got b%0d d%b want b%0d d1", i, BIN, DIR, (i + 1) % 8);
         end
         steps += int'(STEP);
      end
      checks++;
      if (steps != 8 || POS !== 8'd8 || ERR_CNT !== 4'd0) begin
         errors++;
         $display("FAIL up_total got steps%0d pos%0d ec%0d want 8 8 0", steps, POS, ERR_CNT);
      end
   endtask

   task automatic test_count_down;
      logic [2:0] seq [3] = '{3'b100, 3'b101, 3'b111};
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, seq[i]);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL down_%0d got %h want %h", i, obs, e);
         end
         checks++;
         if (STEP !== 1'b1 || DIR !== 1'b0 || BIN !== 3'(7 - i)) begin
            errors++;
            $display("FAIL down_fields_%0d got s%b d%b b%0d want s1 d0 b%0d",
                     i, STEP, DIR, BIN, 7 - i);
         end
      end
      checks++;
      if (POS !== 8'd5) begin
         errors++;
         $display("FAIL down_pos got %0d want 5", POS);
      end
   endtask

   task automatic test_illegal_resync;
      logic [2:0] seq [5] = '{3'b101, 3'b100, 3'b000, 3'b010, 3'b110};
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, seq[i]);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL illegal_%0d got %h want %h", i, obs, e);
         end
         if (i == 3) begin
            checks++;
            if ({ERR, STEP, POS, ERR_CNT, BIN} !== {1'b1, 1'b0, 8'd8, 4'd1, 3'd3}) begin
               errors++;
               $display("FAIL illegal_jump got e%b s%b p%0d ec%0d b%0d want e1 s0 p8 ec1 b3",
                        ERR, STEP, POS, ERR_CNT, BIN);
            end
         end
      end
      checks++;
      if ({STEP, DIR, ERR, POS} !== {1'b1, 1'b1, 1'b0, 8'd9}) begin
         errors++;
         $display("FAIL resync_step got s%b d%b e%b p%0d want s1 d1 e0 p9", STEP, DIR, ERR, POS);
      end
   endtask

   task automatic test_saturation;
      step(1'b1, 1'b0, 3'b000);
      void'(sb.pop_front());
      step(1'b0, 1'b1, 3'b000);
      void'(sb.pop_front());
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, (i % 2 == 0) ? 3'b010 : 3'b000);
         e = sb.pop_front();
         checks++;
         if (obs !== e || ERR !== 1'b1 || STEP !== 1'b0) begin
            errors++;
            $display("FAIL sat_%0d got %h want %h", i, obs, e);
         end
      end
      checks++;
      if (ERR_CNT !== 4'd15) begin
         errors++;
         $display("FAIL sat_count got %0d want 15", ERR_CNT);
      end
      step(1'b0, 1'b1, 3'b100);
      e = sb.pop_front();
      checks++;
      if (obs !== e || POS !== 8'd255 || ERR_CNT !== 4'd15) begin
         errors++;
         $display("FAIL pos_wrap got pos%0d ec%0d want 255 15", POS, ERR_CNT);
      end
   endtask

   task automatic test_en_hold_reset;
      logic [2:0] seq [3] = '{3'b000, 3'b001, 3'b011};
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, seq[i]);
         e = sb.pop_front();
         checks++;
         if (obs !== e || STEP !== 1'b0 || ERR !== 1'b0 || BIN !== 3'd7 || POS !== 8'd255) begin
            errors++;
            $display("FAIL en_hold_%0d got %h want %h", i, obs, e);
         end
      end
      step(1'b0, 1'b1, 3'b011);
      e = sb.pop_front();
      checks++;
      if (obs !== e || ERR !== 1'b1) begin
         errors++;
         $display("FAIL en_resume got %h want %h", obs, e);
      end
      step(1'b1, 1'b1, 3'b001);
      e = sb.pop_front();
      checks++;
      if (obs !== e || obs !== '0) begin
         errors++;
         $display("FAIL mid_reset got %h want %h", obs, e);
      end
      step(1'b0, 1'b1, 3'b001);
      e = sb.pop_front();
      checks++;
      if (obs !== e || {VALID, BIN, STEP, ERR} !== {1'b1, 3'd1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL rebaseline got %h want %h", obs, e);
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0] g;
      for (int i = 0; i < 40; i++) begin
         g = 3'($urandom_range(0, 7));
         step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, g);
         e = sb.pop_front();
         checks++;
         if (obs !== e || (STEP === 1'b1 && ERR === 1'b1)) begin
            errors++;
            $display("FAIL random_%0d got %h want %h", i, obs, e);
         end
      end
   endtask

   initial begin
      @(negedge CLK);
      test_reset();
      test_count_up();
      test_count_down();
      test_illegal_resync();
      test_saturation();
      test_en_hold_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gray_step_decoder.md
Name: gray_step_decoder

Overview:
- Receive-side companion to the lab's 3-bit Gray-code up/down counter FSM.
- Watches the counter's 3-bit Gray output (LED pattern Y3..Y1) each clock and recovers:
  - the binary value;
  - step direction;
  - a wrapping position count;
  - illegal-jump errors.
- Sits beside the counter in the lab top level so the pair can be checked against each other in simulation and on the board.

Parameters:
- POS_W, 8, width of the position accumulator POS.
- ERR_W, 4, width of the saturating error counter ERR_CNT.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- EN  input  1  sample enable; when 0 all state holds and no pulses are issued.
- G  input  3  Gray code under observation, G[2] = MSB (counter's Y3,Y2,Y1).
- BIN  output  3  binary equivalent of the last accepted code.
- VALID  output  1  high once a baseline code has been captured.
- STEP  output  1  one-cycle pulse: a legal single step was detected.
- DIR  output  1  direction of the last legal step (1 = up, 0 = down); holds between steps.
- ERR  output  1  one-cycle pulse: an illegal jump was detected.
- POS  output  POS_W  signed-agnostic up/down position count, wraps modulo 2^POS_W.
- ERR_CNT  output  ERR_W  number of illegal jumps, saturating.

Behaviour:
Reset and clocking:
- Single clock CLK; reset is synchronous and active-high.
- Reset (sampled on a CLK rising edge) forces:
  - BIN=000, VALID=0, STEP=0, DIR=0, ERR=0;
  - POS=0, ERR_CNT=0;
  - internal previous-value register P=000.
- reset has priority over EN and G.
- Reset mid-operation discards history. The next enabled sample becomes the new baseline.

Conversion (combinational on G):
- b2=G2, b1=G2^G1, b0=b1^G0.

States:
- INIT (VALID=0): the first edge with EN=1 loads P<=b and BIN<=b, then moves to TRACK (VALID<=1). No STEP or ERR in this cycle, and POS is unchanged.
- TRACK (VALID=1): each edge with EN=1 computes D=(b-P) mod 8 (3-bit subtract) and acts on it:
  - D=0: no pulse; all outputs hold except STEP/ERR, which return to 0.
  - D=1: STEP<=1, DIR<=1, POS<=POS+1 (wraps from all-ones to 0).
  - D=7: STEP<=1, DIR<=0, POS<=POS-1 (wraps from 0 to all-ones).
  - D in 2..6: ERR<=1, and ERR_CNT<=ERR_CNT+1 unless it is all-ones (saturates). DIR and POS are unchanged.
  - In every TRACK case: P<=b and BIN<=b. The decoder resynchronises to the new code after an error.

EN=0:
- No state change. STEP and ERR are forced to 0 on that edge. P, BIN, POS, ERR_CNT, DIR and VALID hold.

Timing:
- STEP and ERR are registered. Each is high for exactly the one cycle after the edge that sampled the changed code, so latency is 1 clock from G change to pulse.
- STEP and ERR are never high together.

Wrap-around:
- Gray 100 (bin 7) -> 000 (bin 0) is D=1, i.e. a legal up step.
- 000 -> 100 is D=7, i.e. a legal down step.

Input timing:
- G is treated as synchronous to CLK (driven by the counter on the same clock). No synchroniser is included.

Test Plan:
1. Reset then baseline:
   - Stimulus: reset=1 for 2 edges, then EN=1, G=000.
   - Required: VALID=0 during reset. After the first enabled edge, VALID=1, BIN=000, STEP=0, POS=0.
2. Count up with wrap:
   - Stimulus: from baseline G=000, drive the Gray sequence 001,011,010,110,111,101,100,000, one code per clock.
   - Required: 8 STEP pulses with DIR=1, BIN follows 1..7,0, POS=8, ERR_CNT=0.
3. Count down through wrap:
   - Stimulus: from G=000, POS=8, drive 100,101,111.
   - Required: 3 STEP pulses with DIR=0, BIN=7,6,5, POS=5.
4. Illegal jump and resync:
   - Stimulus: from G=000 (bin 0), drive G=010 (bin 3), then 110 (bin 4).
   - Required: first edge gives ERR=1, STEP=0, POS unchanged, ERR_CNT=1, BIN=3. Next edge gives STEP=1, DIR=1, POS+1.
5. ERR_CNT saturation and POS wrap down:
   - Stimulus: from reset/baseline at 000, toggle G between 000 and 010 for 20 clocks, then drive the single step 000->100.
   - Required: ERR_CNT stops at 15 (ERR_W=4) while ERR keeps pulsing. After the step, POS=255 (POS_W=8).
6. EN hold and mid-run reset:
   - Stimulus: EN=0 while G moves 000->001->011.
   - Required: no pulses; BIN and POS hold.
   - Stimulus: then EN=1 with G=011.
   - Required: D=3, so ERR=1.
   - Stimulus: then assert reset for 1 edge with G=001.
   - Required: all outputs return to reset values. The next enabled edge rebaselines to BIN=1 with no pulse.
